// File: rtl/poly_mul_pkg.sv
// poly_mul_pkg
// Shared definitions for the polynomial-multiplier control slice:
//   - widths of the conf opcode bus and the done_flag completion code
//   - conf opcode constants understood by top_poly_mul
//   - sequencer state encoding
//   - packed step-table entry {conf, flag}
package poly_mul_pkg;

    localparam int POLY_CONF_W = 3;
    localparam int POLY_FLAG_W = 3;

    // Opcodes driven on conf; CONF_IDLE parks top_poly_mul between operations.
    localparam logic [POLY_CONF_W-1:0] CONF_IDLE  = 3'd0;
    localparam logic [POLY_CONF_W-1:0] CONF_NTT   = 3'd1;
    localparam logic [POLY_CONF_W-1:0] CONF_NTT_B = 3'd3;
    localparam logic [POLY_CONF_W-1:0] CONF_PWM   = 3'd4;
    localparam logic [POLY_CONF_W-1:0] CONF_INTT  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_GAP  = 2'd2
    } seq_state_t;

    // One programmed step: the opcode to issue and the done_flag code that ends it.
    typedef struct packed {
        logic [POLY_CONF_W-1:0] conf;
        logic [POLY_FLAG_W-1:0] flag;
    } step_entry_t;

endpackage

// File: rtl/poly_mul_sequencer_table.sv
// seq_step_table
// Small register file holding the sequencer's step program.
// Ports:
//   clk      in   rising-edge clock for writes
//   wr_en    in   write strobe (already qualified by the caller)
//   wr_addr  in   entry to write
//   wr_data  in   packed {conf, flag} entry
//   rd_addr  in   entry to read
//   rd_data  out  combinational read of rd_addr
// The storage is deliberately not reset: software always programs it before use.
module seq_step_table
    import poly_mul_pkg::*;
#(
    parameter int MAX_STEPS = 8,
    parameter int STEP_W    = $clog2(MAX_STEPS),
    parameter int ENTRY_W   = $bits(step_entry_t)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [STEP_W-1:0]  wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [STEP_W-1:0]  rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] mem [MAX_STEPS];

    // Synchronous write port; a write lands at the edge and is readable the next cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/poly_mul_sequencer.sv
// poly_mul_sequencer
// Steps top_poly_mul through a programmed list of opcodes. Each step drives an
// opcode on conf and waits for the matching done_flag code, with protection
// against a flag left over from the previous step, optional idle gaps between
// steps, a per-step watchdog and an abort.
// Ports:
//   clk, rst        clock and asynchronous active-low reset
//   start, abort    begin a sequence (from IDLE) / abandon it (any state)
//   num_steps       steps to run, clamped to MAX_STEPS, latched at start
//   timeout_limit   per-step watchdog limit in WAIT cycles, 0 disables
//   prog_*          step-table write port, ignored while busy
//   done_flag       completion code from top_poly_mul
//   conf            registered opcode to top_poly_mul
//   busy, step_idx  sequence running / current step
//   seq_done        one-cycle pulse when every step has completed
//   timeout_err     sticky watchdog error, cleared by the next sequence start
module poly_mul_sequencer
    import poly_mul_pkg::*;
#(
    parameter int CONF_W     = POLY_CONF_W,
    parameter int FLAG_W     = POLY_FLAG_W,
    parameter int MAX_STEPS  = 8,
    parameter int STEP_W     = $clog2(MAX_STEPS),
    parameter int GAP_CYCLES = 1,
    parameter int TO_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [STEP_W:0]   num_steps,
    input  logic [TO_W-1:0]   timeout_limit,
    input  logic              prog_we,
    input  logic [STEP_W-1:0] prog_addr,
    input  logic [CONF_W-1:0] prog_conf,
    input  logic [FLAG_W-1:0] prog_flag,
    input  logic [FLAG_W-1:0] done_flag,
    output logic [CONF_W-1:0] conf,
    output logic              busy,
    output logic [STEP_W-1:0] step_idx,
    output logic              seq_done,
    output logic              timeout_err
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [STEP_W:0] MAX_COUNT = (STEP_W + 1)'(MAX_STEPS);

    seq_state_t        state, state_n;
    step_entry_t       wr_entry, rd_entry;
    logic [STEP_W-1:0] rd_addr;
    logic [STEP_W:0]   steps_clamped;

    logic [CONF_W-1:0] conf_n;
    logic              busy_n, seq_done_n, timeout_err_n;
    logic [STEP_W-1:0] step_n, last_idx, last_n;
    logic [FLAG_W-1:0] cur_flag, flag_n;
    logic              armed, armed_n;
    logic [TO_W-1:0]   wdog, wdog_n;
    logic [GAP_W-1:0]  gap_cnt, gap_n;

    logic flag_match, step_complete, is_last, wdog_hit;

    assign wr_entry = '{conf: prog_conf, flag: prog_flag};

    seq_step_table #(
        .MAX_STEPS (MAX_STEPS),
        .STEP_W    (STEP_W)
    ) u_table (
        .clk     (clk),
        .wr_en   (prog_we && !busy),
        .wr_addr (prog_addr),
        .wr_data (wr_entry),
        .rd_addr (rd_addr),
        .rd_data (rd_entry)
    );

    // The only entry ever loaded from IDLE is step 0; everywhere else the
    // sequencer is about to move on to step_idx+1.  The expected flag of the
    // running step is held in cur_flag, so one read port is enough.
    assign rd_addr       = (state == ST_IDLE) ? '0 : step_idx + 1'b1;
    assign steps_clamped = (num_steps > MAX_COUNT) ? MAX_COUNT : num_steps;
    assign flag_match    = (done_flag == cur_flag);
    assign step_complete = (state == ST_WAIT) && armed && flag_match;
    assign is_last       = (step_idx == last_idx);
    assign wdog_hit      = (timeout_limit != '0) && (wdog == timeout_limit - 1'b1);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and next-output logic. Abort overrides everything. A step only
    // completes once the flag has been seen to differ from the expected code
    // (armed), so a code still held over from the previous step cannot end the
    // new one. Completion is checked before the watchdog so a tie goes to
    // completion.
    always_comb begin
        state_n       = state;
        conf_n        = conf;
        busy_n        = busy;
        step_n        = step_idx;
        seq_done_n    = 1'b0;
        timeout_err_n = timeout_err;
        armed_n       = armed;
        wdog_n        = wdog;
        gap_n         = gap_cnt;
        last_n        = last_idx;
        flag_n        = cur_flag;

        if (abort) begin
            state_n = ST_IDLE;
            conf_n  = CONF_IDLE;
            busy_n  = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (steps_clamped == '0) begin
                            seq_done_n = 1'b1;
                        end else begin
                            state_n       = ST_WAIT;
                            conf_n        = rd_entry.conf;
                            flag_n        = rd_entry.flag;
                            step_n        = '0;
                            busy_n        = 1'b1;
                            timeout_err_n = 1'b0;
                            armed_n       = 1'b0;
                            wdog_n        = '0;
                            last_n        = STEP_W'(steps_clamped - 1'b1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (!armed && !flag_match) begin
                        armed_n = 1'b1;
                    end
                    if (wdog != '1) begin
                        wdog_n = wdog + 1'b1;
                    end
                    if (step_complete) begin
                        if (is_last) begin
                            state_n    = ST_IDLE;
                            conf_n     = CONF_IDLE;
                            seq_done_n = 1'b1;
                            busy_n     = 1'b0;
                        end else if (GAP_CYCLES > 0) begin
                            state_n = ST_GAP;
                            conf_n  = CONF_IDLE;
                            gap_n   = '0;
                        end else begin
                            conf_n  = rd_entry.conf;
                            flag_n  = rd_entry.flag;
                            step_n  = step_idx + 1'b1;
                            armed_n = 1'b0;
                            wdog_n  = '0;
                        end
                    end else if (wdog_hit) begin
                        state_n       = ST_IDLE;
                        conf_n        = CONF_IDLE;
                        timeout_err_n = 1'b1;
                        busy_n        = 1'b0;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state_n = ST_WAIT;
                        conf_n  = rd_entry.conf;
                        flag_n  = rd_entry.flag;
                        step_n  = step_idx + 1'b1;
                        armed_n = 1'b0;
                        wdog_n  = '0;
                    end else begin
                        gap_n = gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    conf_n  = CONF_IDLE;
                    busy_n  = 1'b0;
                end
            endcase
        end
    end

    // Output and bookkeeping registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conf        <= CONF_IDLE;
            busy        <= 1'b0;
            step_idx    <= '0;
            seq_done    <= 1'b0;
            timeout_err <= 1'b0;
            armed       <= 1'b0;
            wdog        <= '0;
            gap_cnt     <= '0;
            last_idx    <= '0;
            cur_flag    <= '0;
        end else begin
            conf        <= conf_n;
            busy        <= busy_n;
            step_idx    <= step_n;
            seq_done    <= seq_done_n;
            timeout_err <= timeout_err_n;
            armed       <= armed_n;
            wdog        <= wdog_n;
            gap_cnt     <= gap_n;
            last_idx    <= last_n;
            cur_flag    <= flag_n;
        end
    end

endmodule
